hamming_serial_tx: RTL and testbench

//   Transmit side of the Hamming(7,4)-protected serial register link.
//   - Accepts a WIDTH-bit data word through a valid/ready handshake.
//   - Encodes each 4-bit nibble into a 7-bit codeword.
//   - Shifts the resulting frame out one bit at a time at a programmable bit rate.
//   - Has an optional single-bit error injection, so the bench can exercise the

---
 rtl/hamming_serial_tx_if.sv | 27 ++
 rtl/hamming_serial_tx.sv | 115 +++++++++++
 tb/tb_hamming_serial_tx.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hamming_serial_tx_if.sv
// Handshake and serial-output bundle for the Hamming(7,4) serial transmitter.
interface hamming_serial_tx_if #(
   parameter int unsigned WIDTH = 16
);
   localparam int unsigned POS_W = $clog2(7 * (WIDTH / 4));

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             inj_en;
   logic [POS_W-1:0] inj_pos;
   logic             tx_bit;
   logic             tx_valid;
   logic             tx_start;
   logic             tx_last;
   logic             busy;

   modport master (
      output in_valid, in_data, inj_en, inj_pos,
      input  in_ready, tx_bit, tx_valid, tx_start, tx_last, busy
   );

   modport slave (
      input  in_valid, in_data, inj_en, inj_pos,
      output in_ready, tx_bit, tx_valid, tx_start, tx_last, busy
   );
endinterface

// File: rtl/hamming_serial_tx.sv
// Hamming(7,4) frame encoder and serialiser with optional single-bit error injection.
// Nibble 0 is sent first, each codeword LSB first: d0,d1,d2,d3,p1,p2,p3.
module hamming_serial_tx #(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic                clk,
   input  logic                rst,
   hamming_serial_tx_if.slave  bus
);
   localparam int unsigned BLOCKS     = WIDTH / 4;
   localparam int unsigned FRAME_BITS = 7 * BLOCKS;
   localparam int unsigned POS_W      = $clog2(FRAME_BITS);
   localparam int unsigned DIV_W      = $clog2(CLKS_PER_BIT + 1);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t                r_state;
   logic [FRAME_BITS-1:0] r_sr;
   logic [POS_W-1:0]      r_bit_cnt;
   logic [DIV_W-1:0]      r_div_cnt;
   logic                  r_tx_bit;
   logic                  r_tx_valid;
   logic                  r_tx_start;
   logic                  r_tx_last;

   state_t                w_state_nxt;
   logic [FRAME_BITS-1:0] w_sr_nxt;
   logic [POS_W-1:0]      w_bit_nxt;
   logic [DIV_W-1:0]      w_div_nxt;
   logic [FRAME_BITS-1:0] w_frame;
   logic [FRAME_BITS-1:0] w_mask;
   logic [3:0]            w_nib;
   logic                  w_send_nxt;

   // Encoded frame and one-hot injection mask; out-of-range positions match no bit
   always_comb begin
      w_frame = '0;
      w_mask  = '0;
      w_nib   = '0;
      for (int i = 0; i < int'(BLOCKS); i++) begin
         w_nib = bus.in_data[4*i +: 4];
         w_frame[7*i +: 7] = {w_nib[0] ^ w_nib[1] ^ w_nib[2],
                              w_nib[0] ^ w_nib[1] ^ w_nib[3],
                              w_nib[0] ^ w_nib[2] ^ w_nib[3],
                              w_nib};
      end
      for (int k = 0; k < int'(FRAME_BITS); k++) begin
         w_mask[k] = bus.inj_en && (bus.inj_pos == POS_W'(k));
      end
   end

   // Next-state logic; outputs are precomputed from next values so they register in step
   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_bit_nxt   = r_bit_cnt;
      w_div_nxt   = r_div_cnt;
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_sr_nxt    = w_frame ^ w_mask;
               w_bit_nxt   = '0;
               w_div_nxt   = '0;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (r_div_cnt == DIV_W'(CLKS_PER_BIT - 1)) begin
               w_div_nxt = '0;
               w_sr_nxt  = r_sr >> 1;
               if (r_bit_cnt == POS_W'(FRAME_BITS - 1)) begin
                  w_bit_nxt   = '0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_bit_nxt = r_bit_cnt + POS_W'(1);
               end
            end else begin
               w_div_nxt = r_div_cnt + DIV_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_send_nxt = (w_state_nxt == S_SEND);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_sr       <= '0;
         r_bit_cnt  <= '0;
         r_div_cnt  <= '0;
         r_tx_bit   <= 1'b0;
         r_tx_valid <= 1'b0;
         r_tx_start <= 1'b0;
         r_tx_last  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sr       <= w_sr_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_div_cnt  <= w_div_nxt;
         r_tx_bit   <= w_send_nxt & w_sr_nxt[0];
         r_tx_valid <= w_send_nxt;
         r_tx_start <= w_send_nxt && (w_bit_nxt == '0);
         r_tx_last  <= w_send_nxt && (w_bit_nxt == POS_W'(FRAME_BITS - 1));
      end
   end

   assign bus.in_ready = (r_state == S_IDLE);
   assign bus.tx_bit   = r_tx_bit;
   assign bus.tx_valid = r_tx_valid;
   assign bus.tx_start = r_tx_start;
   assign bus.tx_last  = r_tx_last;
   assign bus.busy     = r_tx_valid;
endmodule

// File: tb/tb_hamming_serial_tx.sv
// Bench for hamming_serial_tx: table vectors, random words against a frame model,
// back-to-back streaming and mid-frame reset, on CLKS_PER_BIT=1 and 3 instances.
module tb_hamming_serial_tx;
   localparam int FB = 28;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   hamming_serial_tx_if #(.WIDTH(16)) if1 ();
   hamming_serial_tx_if #(.WIDTH(16)) if3 ();

   hamming_serial_tx #(.WIDTH(16), .CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   hamming_serial_tx #(.WIDTH(16), .CLKS_PER_BIT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

   typedef struct {
      logic [15:0] data;
      logic        en;
      logic [4:0]  pos;
      logic [27:0] exp;
   } vec_t;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: parity is the even-weight of the covered data bits
   function automatic logic [27:0] model(input logic [15:0] d, input logic en, input logic [4:0] pos);
      longint f = 0;
      for (int b = 0; b < 4; b++) begin
         int nib = int'((d >> (4 * b)) & 16'hF);
         int p1  = $countones(4'(nib & 4'b1101)) % 2;
         int p2  = $countones(4'(nib & 4'b1011)) % 2;
         int p3  = $countones(4'(nib & 4'b0111)) % 2;
         longint cw = longint'(nib + 16 * p1 + 32 * p2 + 64 * p3);
         f = f + (cw << (7 * b));
      end
      if (en && pos < 5'(FB)) f = f ^ (longint'(1) << pos);
      return 28'(f);
   endfunction

   // Called just after the accept edge; captures one frame and audits the framing flags
   task automatic collect(input int sel, output logic [27:0] frame, output int nvalid,
                          output int ctl_err, output bit first_ok);
      int  cpb = (sel != 0) ? 3 : 1;
      logic v, b, s, l, r, bz;
      frame = '0; nvalid = 0; ctl_err = 0; first_ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         v  = sel != 0 ? if3.tx_valid : if1.tx_valid;
         b  = sel != 0 ? if3.tx_bit   : if1.tx_bit;
         s  = sel != 0 ? if3.tx_start : if1.tx_start;
         l  = sel != 0 ? if3.tx_last  : if1.tx_last;
         r  = sel != 0 ? if3.in_ready : if1.in_ready;
         bz = sel != 0 ? if3.busy     : if1.busy;
         if (c == 0) begin
            first_ok = v;
            if1.in_valid = 1'b0;
            if3.in_valid = 1'b0;
         end
         if (v) begin
            int idx = nvalid / cpb;
            if (idx < FB) begin
               if (nvalid % cpb == 0) frame[idx] = b;
               else if (frame[idx] != b) ctl_err++;
            end
            if (s != (nvalid < cpb)) ctl_err++;
            if (l != (nvalid >= (FB - 1) * cpb)) ctl_err++;
            if (r || !bz) ctl_err++;
            nvalid++;
         end else if (nvalid > 0) begin
            break;
         end
      end
   endtask

   task automatic send(input int sel, input string name, input logic [15:0] d,
                       input logic en, input logic [4:0] pos, input logic [27:0] exp);
      logic [27:0] frame;
      int nvalid, ctl_err;
      bit first_ok;
      int cpb = (sel != 0) ? 3 : 1;
      for (int k = 0; k < 200; k++) begin
         if ((sel != 0) ? if3.in_ready : if1.in_ready) break;
         @(negedge clk);
      end
      if (sel != 0) begin
         if3.in_data = d; if3.inj_en = en; if3.inj_pos = pos; if3.in_valid = 1'b1;
      end else begin
         if1.in_data = d; if1.inj_en = en; if1.inj_pos = pos; if1.in_valid = 1'b1;
      end
      @(posedge clk);
      collect(sel, frame, nvalid, ctl_err, first_ok);
      chk({name, " latency"}, longint'(first_ok), 1);
      chk({name, " frame"}, longint'(frame), longint'(exp));
      chk({name, " valid_cycles"}, longint'(nvalid), longint'(FB * cpb));
      chk({name, " flags"}, longint'(ctl_err), 0);
   endtask

   initial begin
      vec_t vecs[6];
      logic [15:0] rd;
      logic ren;
      logic [4:0] rpos;
      logic [27:0] frame, exp_cur;
      int nvalid, ctl_err, idx, acc_n, derr, rerr, gap_err, cnt;
      int acc_c[8];
      logic [15:0] acc_d[8];
      bit first_ok, prev_v, toggle_pend;
      logic v, b, r;

      vecs[0] = '{16'h000B, 1'b0, 5'd0,  28'h000002B};
      vecs[1] = '{16'hFFFF, 1'b0, 5'd0,  28'hFFFFFFF};
      vecs[2] = '{16'hFFFF, 1'b1, 5'd2,  28'hFFFFFFB};
      vecs[3] = '{16'hFFFF, 1'b1, 5'd30, 28'hFFFFFFF};
      vecs[4] = '{16'h0000, 1'b0, 5'd0,  28'h0000000};
      vecs[5] = '{16'h0001, 1'b1, 5'd27, 28'h8000071};

      if1.in_valid = 1'b0; if1.in_data = '0; if1.inj_en = 1'b0; if1.inj_pos = '0;
      if3.in_valid = 1'b0; if3.in_data = '0; if3.inj_en = 1'b0; if3.inj_pos = '0;

      repeat (3) @(negedge clk);
      chk("reset in_ready", longint'(if1.in_ready), 1);
      chk("reset outputs", longint'({if1.tx_bit, if1.tx_valid, if1.tx_start, if1.tx_last, if1.busy}), 0);
      chk("reset outputs cpb3", longint'({if3.tx_valid, if3.busy, if3.in_ready}), 1);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) send(0, $sformatf("vec%0d", i), vecs[i].data, vecs[i].en, vecs[i].pos, vecs[i].exp);
      send(1, "cpb3 000B", 16'h000B, 1'b0, 5'd0, 28'h000002B);

      for (int i = 0; i < 24; i++) begin
         rd = 16'($urandom); ren = 1'($urandom); rpos = 5'($urandom_range(0, 31));
         send(0, $sformatf("rand%0d", i), rd, ren, rpos, model(rd, ren, rpos));
      end
      for (int i = 0; i < 4; i++) begin
         rd = 16'($urandom); ren = 1'($urandom); rpos = 5'($urandom_range(0, 31));
         send(1, $sformatf("rand3_%0d", i), rd, ren, rpos, model(rd, ren, rpos));
      end

      // Back-to-back streaming with in_valid held high
      acc_n = 0; derr = 0; rerr = 0; gap_err = 0; idx = 0; prev_v = 1'b0; toggle_pend = 1'b0;
      exp_cur = '0;
      if1.inj_en = 1'b0; if1.in_data = 16'h1234; if1.in_valid = 1'b1;
      for (int c = 0; c < 90; c++) begin
         v = if1.tx_valid; b = if1.tx_bit; r = if1.in_ready;
         if (toggle_pend) begin
            if1.in_data = (if1.in_data == 16'h1234) ? 16'hABCD : 16'h1234;
            toggle_pend = 1'b0;
         end
         if (v) begin
            if (idx < FB && b != exp_cur[idx]) derr++;
            idx++;
            if (r) rerr++;
         end
         if (r && if1.in_valid) begin
            if (acc_n > 0 && !prev_v) gap_err++;
            if (acc_n < 8) begin acc_c[acc_n] = c; acc_d[acc_n] = if1.in_data; end
            acc_n++;
            exp_cur = model(if1.in_data, 1'b0, 5'd0);
            idx = 0;
            toggle_pend = 1'b1;
         end
         prev_v = v;
         @(negedge clk);
      end
      if1.in_valid = 1'b0;
      chk("stream accepts", longint'(acc_n), 4);
      chk("stream period1", longint'(acc_c[1] - acc_c[0]), 29);
      chk("stream period2", longint'(acc_c[2] - acc_c[1]), 29);
      chk("stream period3", longint'(acc_c[3] - acc_c[2]), 29);
      chk("stream data2", longint'(acc_d[1]), longint'(16'hABCD));
      chk("stream bits", longint'(derr), 0);
      chk("stream ready_in_send", longint'(rerr), 0);
      chk("stream gap", longint'(gap_err), 0);
      for (int k = 0; k < 100 && !if1.in_ready; k++) @(negedge clk);

      // Reset during bit 10, then a fresh frame accepted right at reset release
      if1.in_data = 16'hFFFF; if1.inj_en = 1'b0; if1.in_valid = 1'b1;
      @(posedge clk);
      cnt = 0;
      for (int k = 0; k < 100 && cnt < 11; k++) begin
         @(negedge clk);
         if1.in_valid = 1'b0;
         if (if1.tx_valid) cnt++;
      end
      chk("midframe reached bit10", longint'(cnt), 11);
      rst = 1'b0;
      #1;
      chk("midreset outputs", longint'({if1.tx_bit, if1.tx_valid, if1.tx_start, if1.tx_last, if1.busy}), 0);
      chk("midreset in_ready", longint'(if1.in_ready), 1);
      if1.in_data = 16'h000B; if1.in_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("held reset outputs", longint'({if1.tx_valid, if1.busy, if1.in_ready}), 1);
      rst = 1'b1;
      @(posedge clk);
      collect(0, frame, nvalid, ctl_err, first_ok);
      chk("post reset latency", longint'(first_ok), 1);
      chk("post reset frame", longint'(frame), longint'(28'h000002B));
      chk("post reset valid_cycles", longint'(nvalid), FB);
      chk("post reset flags", longint'(ctl_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
